id_stage: RTL and testbench

- Instruction-decode stage that sits directly downstream of the fetch/next-PC block and consumes its 32-bit `instruction` word.
- Contains the 32x32 register file with a writeback port.
- Decodes MIPS opcode/funct into control strobes, reads the rs/rt operands and sign- or zero-extends the immediate.
- Presents everything through one registered pipeline stage to the execute/ALU stage.

---
 rtl/id_stage.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage.
//   Holds the 32-entry register file (one writeback port), decodes opcode into
//   control strobes, reads rs/rt, extends the immediate and registers all of it
//   into one pipeline stage towards execute.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   instruction/instr_valid - instruction word from fetch and its valid flag
//   stall, flush            - hold / squash the pipeline register
//   wb_en/wb_addr/wb_data   - register file writeback port
//   id_valid .. illegal_op  - registered decode outputs to execute
// Build option:
//   ID_STAGE_BYPASS_EN - when defined, a writeback on the capture edge is
//   forwarded into the captured rs_data/rt_data.
module id_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_COUNT = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [31:0]       imm_ext,
    output logic [25:0]       jmp_target,
    output logic [4:0]        dest_addr,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              jump,
    output logic              alu_src,
    output logic              illegal_op
);

    localparam int unsigned AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Instruction fields
    logic [5:0]    in_op;
    logic [5:0]    in_funct;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [AW-1:0] in_rd;
    logic [15:0]   in_imm;

    assign in_op    = instruction[31:26];
    assign in_funct = instruction[5:0];
    assign in_rs    = instruction[25:21];
    assign in_rt    = instruction[20:16];
    assign in_rd    = instruction[15:11];
    assign in_imm   = instruction[15:0];

    // Register file
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic              wb_fire;

    // Address 0 is hard-wired zero, so writes to it are dropped
    assign wb_fire = wb_en && (wb_addr != '0) && (32'(wb_addr) < REG_COUNT);

    always_comb begin
        regs_d = regs_q;
        if (wb_fire) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Operand read, with optional same-edge writeback forwarding
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;

    always_comb begin
        rs_rd = '0;
        rt_rd = '0;
        if ((in_rs != '0) && (32'(in_rs) < REG_COUNT)) begin
            rs_rd = regs_q[in_rs];
        end
        if ((in_rt != '0) && (32'(in_rt) < REG_COUNT)) begin
            rt_rd = regs_q[in_rt];
        end
`ifdef ID_STAGE_BYPASS_EN
        if (wb_fire && (wb_addr == in_rs)) begin
            rs_rd = wb_data;
        end
        if (wb_fire && (wb_addr == in_rt)) begin
            rt_rd = wb_data;
        end
`endif
    end

    // Opcode decode
    logic          dec_reg_write;
    logic          dec_mem_read;
    logic          dec_mem_write;
    logic          dec_branch_eq;
    logic          dec_branch_ne;
    logic          dec_jump;
    logic          dec_alu_src;
    logic          dec_illegal;
    logic [AW-1:0] dec_dest;
    logic [31:0]   dec_imm;

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch_eq = 1'b0;
        dec_branch_ne = 1'b0;
        dec_jump      = 1'b0;
        dec_alu_src   = 1'b0;
        dec_illegal   = 1'b0;
        dec_dest      = '0;
        dec_imm       = '0;
        unique case (in_op)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_dest      = in_rd;
            end
            OP_ADDI, OP_SLTI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = in_rt;
                dec_imm       = {{16{in_imm[15]}}, in_imm};
            end
            OP_ANDI, OP_ORI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = in_rt;
                dec_imm       = {16'h0000, in_imm};
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = in_rt;
                dec_imm       = {in_imm, 16'h0000};
            end
            OP_LW: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_dest      = in_rt;
                dec_imm       = {{16{in_imm[15]}}, in_imm};
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = {{16{in_imm[15]}}, in_imm};
            end
            OP_BEQ: begin
                dec_branch_eq = 1'b1;
                dec_imm       = {{16{in_imm[15]}}, in_imm};
            end
            OP_BNE: begin
                dec_branch_ne = 1'b1;
                dec_imm       = {{16{in_imm[15]}}, in_imm};
            end
            OP_J: begin
                dec_jump = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Pipeline register
    logic              id_valid_q,   id_valid_d;
    logic [5:0]        opcode_q,     opcode_d;
    logic [5:0]        funct_q,      funct_d;
    logic [DATA_W-1:0] rs_data_q,    rs_data_d;
    logic [DATA_W-1:0] rt_data_q,    rt_data_d;
    logic [31:0]       imm_ext_q,    imm_ext_d;
    logic [25:0]       jmp_target_q, jmp_target_d;
    logic [AW-1:0]     dest_addr_q,  dest_addr_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              branch_eq_q,  branch_eq_d;
    logic              branch_ne_q,  branch_ne_d;
    logic              jump_q,       jump_d;
    logic              alu_src_q,    alu_src_d;
    logic              illegal_op_q, illegal_op_d;

    // Priority: flush clears, stall holds, bubble clears, otherwise capture
    always_comb begin
        id_valid_d   = id_valid_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_ext_d    = imm_ext_q;
        jmp_target_d = jmp_target_q;
        dest_addr_d  = dest_addr_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        branch_eq_d  = branch_eq_q;
        branch_ne_d  = branch_ne_q;
        jump_d       = jump_q;
        alu_src_d    = alu_src_q;
        illegal_op_d = illegal_op_q;
        if (flush || (!stall && !instr_valid)) begin
            id_valid_d   = 1'b0;
            opcode_d     = '0;
            funct_d      = '0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_ext_d    = '0;
            jmp_target_d = '0;
            dest_addr_d  = '0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            branch_eq_d  = 1'b0;
            branch_ne_d  = 1'b0;
            jump_d       = 1'b0;
            alu_src_d    = 1'b0;
            illegal_op_d = 1'b0;
        end else if (!stall) begin
            id_valid_d   = 1'b1;
            opcode_d     = in_op;
            funct_d      = in_funct;
            rs_data_d    = rs_rd;
            rt_data_d    = rt_rd;
            imm_ext_d    = dec_imm;
            jmp_target_d = instruction[25:0];
            dest_addr_d  = dec_dest;
            reg_write_d  = dec_reg_write;
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
            branch_eq_d  = dec_branch_eq;
            branch_ne_d  = dec_branch_ne;
            jump_d       = dec_jump;
            alu_src_d    = dec_alu_src;
            illegal_op_d = dec_illegal;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q       <= '{default: '0};
            id_valid_q   <= 1'b0;
            opcode_q     <= '0;
            funct_q      <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_ext_q    <= '0;
            jmp_target_q <= '0;
            dest_addr_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_eq_q  <= 1'b0;
            branch_ne_q  <= 1'b0;
            jump_q       <= 1'b0;
            alu_src_q    <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            id_valid_q   <= id_valid_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_ext_q    <= imm_ext_d;
            jmp_target_q <= jmp_target_d;
            dest_addr_q  <= dest_addr_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            branch_eq_q  <= branch_eq_d;
            branch_ne_q  <= branch_ne_d;
            jump_q       <= jump_d;
            alu_src_q    <= alu_src_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign opcode     = opcode_q;
    assign funct      = funct_q;
    assign rs_data    = rs_data_q;
    assign rt_data    = rt_data_q;
    assign imm_ext    = imm_ext_q;
    assign jmp_target = jmp_target_q;
    assign dest_addr  = dest_addr_q;
    assign reg_write  = reg_write_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign branch_eq  = branch_eq_q;
    assign branch_ne  = branch_ne_q;
    assign jump       = jump_q;
    assign alu_src    = alu_src_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, table-driven bench for id_stage.
// Each table row is one clock: inputs driven on the falling edge, outputs
// compared just after the following rising edge.
module tb_id_stage;

    localparam int unsigned DATA_W = 32;

`ifdef ID_STAGE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    // Row input flags {instr_valid, stall, flush, wb_en}
    localparam logic [3:0] I_V = 4'b1000;
    localparam logic [3:0] I_S = 4'b0100;
    localparam logic [3:0] I_F = 4'b0010;
    localparam logic [3:0] I_W = 4'b0001;

    // Expected controls {id_valid, reg_write, mem_read, mem_write, branch_eq,
    //                    branch_ne, jump, alu_src, illegal_op}
    localparam logic [8:0] C_V   = 9'h100;
    localparam logic [8:0] C_RW  = 9'h080;
    localparam logic [8:0] C_MR  = 9'h040;
    localparam logic [8:0] C_MW  = 9'h020;
    localparam logic [8:0] C_BEQ = 9'h010;
    localparam logic [8:0] C_BNE = 9'h008;
    localparam logic [8:0] C_J   = 9'h004;
    localparam logic [8:0] C_AS  = 9'h002;
    localparam logic [8:0] C_ILL = 9'h001;

    logic              clock;
    logic              reset;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              id_valid;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [31:0]       imm_ext;
    logic [25:0]       jmp_target;
    logic [4:0]        dest_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch_eq;
    logic              branch_ne;
    logic              jump;
    logic              alu_src;
    logic              illegal_op;

    id_stage #(.DATA_W(DATA_W), .REG_COUNT(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .id_valid    (id_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .imm_ext     (imm_ext),
        .jmp_target  (jmp_target),
        .dest_addr   (dest_addr),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .alu_src     (alu_src),
        .illegal_op  (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] e_ins;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_imm;
        logic [4:0]  e_dest;
        logic [8:0]  e_ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [8:0] ctl_now();
        return {id_valid, reg_write, mem_read, mem_write, branch_eq,
                branch_ne, jump, alu_src, illegal_op};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [3:0] flags,
                           input logic [4:0] wa, input logic [31:0] wd,
                           input logic chk, input logic [31:0] e_ins,
                           input logic [31:0] e_rs, input logic [31:0] e_rt,
                           input logic [31:0] e_imm, input logic [4:0] e_dest,
                           input logic [8:0] e_ctl);
        vec_t v;
        v.instr = instr;  v.flags = flags;  v.wa = wa;  v.wd = wd;
        v.chk = chk;      v.e_ins = e_ins;  v.e_rs = e_rs;  v.e_rt = e_rt;
        v.e_imm = e_imm;  v.e_dest = e_dest; v.e_ctl = e_ctl;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clock);
        instruction = v.instr;
        instr_valid = v.flags[3];
        stall       = v.flags[2];
        flush       = v.flags[1];
        wb_en       = v.flags[0];
        wb_addr     = v.wa;
        wb_data     = v.wd;
        @(posedge clock);
        #1;
        check($sformatf("v%0d.ctl", i), 32'(ctl_now()), 32'(v.e_ctl));
        if (v.chk) begin
            check($sformatf("v%0d.rs_data", i), rs_data, v.e_rs);
            check($sformatf("v%0d.rt_data", i), rt_data, v.e_rt);
            check($sformatf("v%0d.imm_ext", i), imm_ext, v.e_imm);
            check($sformatf("v%0d.dest_addr", i), 32'(dest_addr), 32'(v.e_dest));
            check($sformatf("v%0d.opcode", i), 32'(opcode), 32'(v.e_ins[31:26]));
            check($sformatf("v%0d.funct", i), 32'(funct), 32'(v.e_ins[5:0]));
            check($sformatf("v%0d.jmp_target", i), 32'(jmp_target), 32'(v.e_ins[25:0]));
        end
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; instruction = '0; instr_valid = 1'b0; stall = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Writeback setup: reg1=5, reg2=0xFFFFFFFE, write to reg0 dropped
        add_vec(32'h0000_0000, I_W, 5'd1, 32'h0000_0005, 1'b0, 0, 0, 0, 0, 0, 9'h000);
        add_vec(32'h0000_0000, I_W, 5'd2, 32'hFFFF_FFFE, 1'b0, 0, 0, 0, 0, 0, 9'h000);
        add_vec(32'h0022_1820, I_V | I_W, 5'd0, 32'h0000_1234, 1'b1,
                32'h0022_1820, 32'h5, 32'hFFFF_FFFE, 32'h0, 5'd3, C_V | C_RW);
        add_vec(32'h0000_1820, I_V, 5'd0, 0, 1'b1,
                32'h0000_1820, 32'h0, 32'h0, 32'h0, 5'd3, C_V | C_RW);
        // Immediate extension
        add_vec(32'h2001_FFFF, I_V, 5'd0, 0, 1'b1,
                32'h2001_FFFF, 32'h0, 32'h5, 32'hFFFF_FFFF, 5'd1, C_V | C_RW | C_AS);
        add_vec(32'h3421_FFFF, I_V, 5'd0, 0, 1'b1,
                32'h3421_FFFF, 32'h5, 32'h5, 32'h0000_FFFF, 5'd1, C_V | C_RW | C_AS);
        add_vec(32'h3C01_1234, I_V, 5'd0, 0, 1'b1,
                32'h3C01_1234, 32'h0, 32'h5, 32'h1234_0000, 5'd1, C_V | C_RW | C_AS);
        add_vec(32'h3021_FFFF, I_V, 5'd0, 0, 1'b1,
                32'h3021_FFFF, 32'h5, 32'h5, 32'h0000_FFFF, 5'd1, C_V | C_RW | C_AS);
        add_vec(32'h2821_FFF0, I_V, 5'd0, 0, 1'b1,
                32'h2821_FFF0, 32'h5, 32'h5, 32'hFFFF_FFF0, 5'd1, C_V | C_RW | C_AS);
        // Branches, jump, store, load
        add_vec(32'h1022_0003, I_V, 5'd0, 0, 1'b1,
                32'h1022_0003, 32'h5, 32'hFFFF_FFFE, 32'h3, 5'd0, C_V | C_BEQ);
        add_vec(32'h1422_0003, I_V, 5'd0, 0, 1'b1,
                32'h1422_0003, 32'h5, 32'hFFFF_FFFE, 32'h3, 5'd0, C_V | C_BNE);
        add_vec(32'h0800_0010, I_V, 5'd0, 0, 1'b1,
                32'h0800_0010, 32'h0, 32'h0, 32'h0, 5'd0, C_V | C_J);
        add_vec(32'hAC43_0004, I_V, 5'd0, 0, 1'b1,
                32'hAC43_0004, 32'hFFFF_FFFE, 32'h0, 32'h4, 5'd0, C_V | C_MW | C_AS);
        add_vec(32'h8C43_0004, I_V, 5'd0, 0, 1'b1,
                32'h8C43_0004, 32'hFFFF_FFFE, 32'h0, 32'h4, 5'd3, C_V | C_RW | C_MR | C_AS);
        // Three stalled cycles writing reg2: the held lw must not change
        for (int k = 0; k < 3; k++) begin
            add_vec(32'h0022_1820, I_V | I_S | I_W, 5'd2, 32'h0000_0077, 1'b1,
                    32'h8C43_0004, 32'hFFFF_FFFE, 32'h0, 32'h4, 5'd3, C_V | C_RW | C_MR | C_AS);
        end
        // Flush wins over stall and clears the stage
        add_vec(32'h0022_1820, I_V | I_S | I_F, 5'd0, 0, 1'b1,
                32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 9'h000);
        // Recapture lw: reg2 write during stall landed
        add_vec(32'h8C43_0004, I_V, 5'd0, 0, 1'b1,
                32'h8C43_0004, 32'h0000_0077, 32'h0, 32'h4, 5'd3, C_V | C_RW | C_MR | C_AS);
        // Illegal opcode, then cleared by a legal capture, then a bubble
        add_vec(32'hFC00_0000, I_V, 5'd0, 0, 1'b0, 0, 0, 0, 0, 0, C_V | C_ILL);
        add_vec(32'h2001_FFFF, I_V, 5'd0, 0, 1'b1,
                32'h2001_FFFF, 32'h0, 32'h5, 32'hFFFF_FFFF, 5'd1, C_V | C_RW | C_AS);
        add_vec(32'h0022_1820, 4'b0000, 5'd0, 0, 1'b0, 0, 0, 0, 0, 0, 9'h000);
        // Writeback proceeds during flush
        add_vec(32'h0022_1820, I_V | I_F | I_W, 5'd4, 32'h0000_0044, 1'b1,
                32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 9'h000);
        add_vec(32'h0080_1820, I_V, 5'd0, 0, 1'b1,
                32'h0080_1820, 32'h0000_0044, 32'h0, 32'h0, 5'd3, C_V | C_RW);
        // Same-edge writeback vs capture on rs, then rt
        add_vec(32'h0022_1820, I_V | I_W, 5'd1, 32'h0000_AAAA, 1'b1,
                32'h0022_1820, BYP ? 32'h0000_AAAA : 32'h5, 32'h0000_0077, 32'h0, 5'd3, C_V | C_RW);
        add_vec(32'h0022_1820, I_V | I_W, 5'd2, 32'h0000_BBBB, 1'b1,
                32'h0022_1820, 32'h0000_AAAA, BYP ? 32'h0000_BBBB : 32'h0000_0077, 32'h0, 5'd3, C_V | C_RW);
        add_vec(32'h0022_1820, I_V, 5'd0, 0, 1'b1,
                32'h0022_1820, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0, 5'd3, C_V | C_RW);

        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("reset.ctl", 32'(ctl_now()), 32'h0);
        check("reset.rs_data", rs_data, 32'h0);
        check("reset.imm_ext", imm_ext, 32'h0);
        check("reset.jmp_target", 32'(jmp_target), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Asynchronous reset mid-stall clears outputs without a clock edge
        @(negedge clock);
        stall = 1'b1; instr_valid = 1'b1; wb_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midreset.ctl", 32'(ctl_now()), 32'h0);
        check("midreset.rs_data", rs_data, 32'h0);
        check("midreset.dest_addr", 32'(dest_addr), 32'h0);
        @(negedge clock);
        reset = 1'b0; stall = 1'b0; instruction = 32'h0022_1820;
        @(posedge clock);
        #1;
        check("post_reset.ctl", 32'(ctl_now()), 32'(C_V | C_RW));
        check("post_reset.rs_data", rs_data, 32'h0);
        check("post_reset.rt_data", rt_data, 32'h0);
        check("post_reset.dest_addr", 32'(dest_addr), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
